// File: rtl/pixel_readout_capture.sv
// Receive-side capture of the camera control strobes: exposure timing, per-row ADC capture
// into a 2-entry stream buffer, and protocol checking. Optional CDS difference via `CDS_EN.
module pixel_readout_capture #(
  parameter int ADC_W     = 8,
  parameter int EXP_CNT_W = 8
) (
  input  logic                    Clk,
  input  logic                    NReset,
  input  logic                    Erase,
  input  logic                    Expose,
  input  logic                    NRE_1,
  input  logic                    NRE_2,
  input  logic                    ADC,
  input  logic [ADC_W-1:0]        Adc_data,
  output logic [ADC_W-1:0]        Pix_data,
  output logic                    Pix_row,
  output logic                    Pix_valid,
  input  logic                    Pix_ready,
  output logic [EXP_CNT_W-1:0]    Exp_cycles,
  output logic                    Frame_done,
  output logic                    Proto_err,
  output logic                    Overrun,
  input  logic                    Err_clr,
  output logic signed [ADC_W:0]   Cds_data,
  output logic                    Cds_valid
);

  typedef enum logic [2:0] {IDLE, EXPOSE, WAIT_R1, ROW1, GAP, ROW2} state_t;

  state_t               state, state_next;
  logic                 got_adc, frame_bad;
  logic [EXP_CNT_W-1:0] exp_cnt;
  logic [ADC_W-1:0]     buf_data [2];
  logic                 buf_row  [2];
  logic                 rd_ptr, wr_ptr;
  logic [1:0]           count;

  logic in_row, row_closing, capture, proto_hit, pop, full, overrun_hit, push, frame_end_ok;

  assign Pix_valid = (count != 2'd0);
  assign Pix_data  = buf_data[rd_ptr];
  assign Pix_row   = buf_row[rd_ptr];

  // Any protocol violation overrides the normal sequence and sends the FSM back to IDLE.
  always_comb begin
    state_next   = state;
    in_row       = (state == ROW1) || (state == ROW2);
    row_closing  = ((state == ROW1) && NRE_1) || ((state == ROW2) && NRE_2);
    capture      = in_row && ADC && !got_adc;
    proto_hit    = (!NRE_1 && !NRE_2)
                 || (ADC && !in_row)
                 || (ADC && in_row && got_adc)
                 || (row_closing && !got_adc && !ADC)
                 || (Expose && (!NRE_1 || !NRE_2))
                 || (Erase && (state != IDLE));
    pop          = Pix_valid && Pix_ready;
    full         = (count == 2'd2);
    overrun_hit  = capture && full && !pop;
    push         = capture && !overrun_hit;
    frame_end_ok = (state == ROW2) && NRE_2 && !proto_hit && !frame_bad && !overrun_hit;
    if (proto_hit) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (Expose)  state_next = EXPOSE;
        EXPOSE:  if (!Expose) state_next = WAIT_R1;
        WAIT_R1: if (!NRE_1)  state_next = ROW1;
        ROW1:    if (NRE_1)   state_next = GAP;
        GAP:     if (!NRE_2)  state_next = ROW2;
        ROW2:    if (NRE_2)   state_next = IDLE;
        default:              state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (!NReset) begin
      state       <= IDLE;
      got_adc     <= 1'b0;
      frame_bad   <= 1'b0;
      exp_cnt     <= '0;
      Exp_cycles  <= '0;
      Frame_done  <= 1'b0;
      Proto_err   <= 1'b0;
      Overrun     <= 1'b0;
      buf_data[0] <= '0;
      buf_data[1] <= '0;
      buf_row[0]  <= 1'b0;
      buf_row[1]  <= 1'b0;
      rd_ptr      <= 1'b0;
      wr_ptr      <= 1'b0;
      count       <= 2'd0;
    end else begin
      state <= state_next;

      // The per-row "already sampled" marker is reset whenever the row window changes.
      if (state_next != state) got_adc <= 1'b0;
      else if (capture)        got_adc <= 1'b1;

      if (proto_hit || overrun_hit)                    frame_bad <= 1'b1;
      else if ((state == IDLE) && (state_next == EXPOSE)) frame_bad <= 1'b0;

      // The entry cycle already has Expose high, so the run starts at one.
      if ((state == IDLE) && (state_next == EXPOSE))
        exp_cnt <= EXP_CNT_W'(1);
      else if ((state == EXPOSE) && Expose && (exp_cnt != {EXP_CNT_W{1'b1}}))
        exp_cnt <= exp_cnt + EXP_CNT_W'(1);
      if ((state == EXPOSE) && (state_next == WAIT_R1))
        Exp_cycles <= exp_cnt;

      Frame_done <= frame_end_ok;
      Proto_err  <= proto_hit   || (Proto_err && !Err_clr);
      Overrun    <= overrun_hit || (Overrun && !Err_clr);

      if (push) begin
        buf_data[wr_ptr] <= Adc_data;
        buf_row[wr_ptr]  <= (state == ROW2);
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

`ifdef CDS_EN
  logic [ADC_W-1:0] row1_sample;

  always_ff @(posedge Clk) begin
    if (!NReset) begin
      row1_sample <= '0;
      Cds_data    <= '0;
      Cds_valid   <= 1'b0;
    end else begin
      Cds_valid <= 1'b0;
      if (capture && (state == ROW1)) row1_sample <= Adc_data;
      if (capture && (state == ROW2)) begin
        Cds_data  <= $signed({1'b0, Adc_data} - {1'b0, row1_sample});
        Cds_valid <= !frame_bad;
      end
    end
  end
`else
  assign Cds_data  = '0;
  assign Cds_valid = 1'b0;
`endif

endmodule

// File: tb/tb_pixel_readout_capture.sv
// Bench for pixel_readout_capture: directed frames from the test plan plus random frames and
// random noise, all checked cycle by cycle against a behavioural frame/queue model.
module tb_pixel_readout_capture;

  localparam int ADC_W     = 8;
  localparam int EXP_CNT_W = 8;
  localparam int EXP_MAX   = (1 << EXP_CNT_W) - 1;

  localparam int P_IDLE = 0, P_EXPOSE = 1, P_WAIT = 2, P_ROW1 = 3, P_GAP = 4, P_ROW2 = 5;

  logic                  Clk = 1'b0;
  logic                  NReset, Erase, Expose, NRE_1, NRE_2, ADC, Pix_ready, Err_clr;
  logic [ADC_W-1:0]      Adc_data;
  logic [ADC_W-1:0]      Pix_data;
  logic                  Pix_row, Pix_valid, Frame_done, Proto_err, Overrun, Cds_valid;
  logic [EXP_CNT_W-1:0]  Exp_cycles;
  logic signed [ADC_W:0] Cds_data;

  always #5 Clk = ~Clk;

  pixel_readout_capture #(.ADC_W(ADC_W), .EXP_CNT_W(EXP_CNT_W)) dut (
    .Clk(Clk), .NReset(NReset), .Erase(Erase), .Expose(Expose), .NRE_1(NRE_1), .NRE_2(NRE_2),
    .ADC(ADC), .Adc_data(Adc_data), .Pix_data(Pix_data), .Pix_row(Pix_row),
    .Pix_valid(Pix_valid), .Pix_ready(Pix_ready), .Exp_cycles(Exp_cycles),
    .Frame_done(Frame_done), .Proto_err(Proto_err), .Overrun(Overrun), .Err_clr(Err_clr),
    .Cds_data(Cds_data), .Cds_valid(Cds_valid)
  );

  int n_vec = 0;
  int n_err = 0;
  int done_seen = 0;

  // Behavioural model: frame phase, sample queue, and sticky flags.
  int         phase;
  logic       m_got, m_bad, m_proto, m_ovr, m_done, m_cds_valid;
  logic [8:0] m_fifo[$];
  int         m_exp_run, m_exp_cycles, m_cds;
  logic [7:0] m_row1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelStep();
    bit in_row, closing, capture, err, pop, ovf;
    int nxt;
    if (!NReset) begin
      phase = P_IDLE; m_got = 0; m_bad = 0; m_proto = 0; m_ovr = 0; m_done = 0;
      m_fifo.delete(); m_exp_run = 0; m_exp_cycles = 0;
      m_cds_valid = 0; m_cds = 0; m_row1 = 0;
      return;
    end
    in_row  = (phase == P_ROW1) || (phase == P_ROW2);
    closing = ((phase == P_ROW1) && NRE_1) || ((phase == P_ROW2) && NRE_2);
    capture = in_row && ADC && !m_got;
    err = (!NRE_1 && !NRE_2) || (ADC && !in_row) || (ADC && in_row && m_got)
       || (closing && !m_got && !ADC) || (Expose && (!NRE_1 || !NRE_2))
       || (Erase && (phase != P_IDLE));
    pop = (m_fifo.size() > 0) && Pix_ready;
    ovf = capture && (m_fifo.size() == 2) && !pop;

    nxt = phase;
    if (err) nxt = P_IDLE;
    else if (phase == P_IDLE   &&  Expose) nxt = P_EXPOSE;
    else if (phase == P_EXPOSE && !Expose) nxt = P_WAIT;
    else if (phase == P_WAIT   && !NRE_1)  nxt = P_ROW1;
    else if (phase == P_ROW1   &&  NRE_1)  nxt = P_GAP;
    else if (phase == P_GAP    && !NRE_2)  nxt = P_ROW2;
    else if (phase == P_ROW2   &&  NRE_2)  nxt = P_IDLE;

    m_done = (phase == P_ROW2) && NRE_2 && !err && !m_bad && !ovf;

    if (phase == P_IDLE && nxt == P_EXPOSE) m_exp_run = 1;
    else if (phase == P_EXPOSE && Expose)   m_exp_run = (m_exp_run < EXP_MAX) ? m_exp_run + 1 : EXP_MAX;
    if (phase == P_EXPOSE && nxt == P_WAIT) m_exp_cycles = m_exp_run;

    m_cds_valid = 0;
    if (capture && phase == P_ROW1) m_row1 = Adc_data;
    if (capture && phase == P_ROW2) begin
      m_cds = int'(Adc_data) - int'(m_row1);
      m_cds_valid = !m_bad;
    end

    if (pop) void'(m_fifo.pop_front());
    if (capture && !ovf) m_fifo.push_back({phase == P_ROW2, Adc_data});

    m_proto = err || (m_proto && !Err_clr);
    m_ovr   = ovf || (m_ovr && !Err_clr);
    if (err || ovf) m_bad = 1;
    else if (phase == P_IDLE && nxt == P_EXPOSE) m_bad = 0;
    if (nxt != phase) m_got = 0;
    else if (capture) m_got = 1;
    phase = nxt;
  endtask

  task automatic checkOutput();
    logic [8:0] cds9;
    check("Pix_valid", {31'b0, Pix_valid}, {31'b0, m_fifo.size() > 0});
    if (m_fifo.size() > 0) begin
      check("Pix_data", {24'b0, Pix_data}, {24'b0, m_fifo[0][7:0]});
      check("Pix_row", {31'b0, Pix_row}, {31'b0, m_fifo[0][8]});
    end
    check("Exp_cycles", {24'b0, Exp_cycles}, m_exp_cycles);
    check("Frame_done", {31'b0, Frame_done}, {31'b0, m_done});
    check("Proto_err", {31'b0, Proto_err}, {31'b0, m_proto});
    check("Overrun", {31'b0, Overrun}, {31'b0, m_ovr});
`ifdef CDS_EN
    cds9 = 9'(m_cds);
    check("Cds_valid", {31'b0, Cds_valid}, {31'b0, m_cds_valid});
    if (m_cds_valid) check("Cds_data", {23'b0, Cds_data[8:0]}, {23'b0, cds9});
`else
    cds9 = 9'd0;
    check("Cds_valid", {31'b0, Cds_valid}, 32'd0);
    check("Cds_data", {23'b0, Cds_data[8:0]}, {23'b0, cds9});
`endif
    if (Frame_done === 1'b1) done_seen++;
  endtask

  task automatic applyStimulus(input logic er, input logic ex, input logic n1, input logic n2,
                               input logic adc, input logic [7:0] d, input logic rdy,
                               input logic clr, input logic nrst);
    Erase = er; Expose = ex; NRE_1 = n1; NRE_2 = n2; ADC = adc; Adc_data = d;
    Pix_ready = rdy; Err_clr = clr; NReset = nrst;
    modelStep();
    @(posedge Clk);
    #1;
    checkOutput();
  endtask

  function automatic logic pickReady(input int mode);
    return (mode == 2) ? logic'($urandom_range(0, 1)) : logic'(mode);
  endfunction

  task automatic idleCycles(input int n, input int rdyMode, input logic clr);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 1, 1, 0, 8'($urandom), pickReady(rdyMode), clr, 1);
  endtask

  // Drives one frame; abortAt > 0 pulls NReset low on that row-2 cycle instead.
  task automatic runFrame(input int expLen, input int r1Len, input int a1, input logic [7:0] d1,
                          input int r2Len, input int a2, input logic [7:0] d2,
                          input int rdyMode, input int abortAt);
    for (int i = 0; i < expLen; i++) applyStimulus(0, 1, 1, 1, 0, 8'($urandom), pickReady(rdyMode), 0, 1);
    applyStimulus(0, 0, 1, 1, 0, 8'($urandom), pickReady(rdyMode), 0, 1);
    for (int i = 1; i <= r1Len; i++)
      applyStimulus(0, 0, 0, 1, i == a1, (i == a1) ? d1 : 8'($urandom), pickReady(rdyMode), 0, 1);
    applyStimulus(0, 0, 1, 1, 0, 8'($urandom), pickReady(rdyMode), 0, 1);
    for (int i = 1; i <= r2Len; i++) begin
      if (i == abortAt) begin
        applyStimulus(0, 0, 0, 1, 0, 8'($urandom), pickReady(rdyMode), 0, 0);
        return;
      end
      applyStimulus(0, 0, 1, 0, i == a2, (i == a2) ? d2 : 8'($urandom), pickReady(rdyMode), 0, 1);
    end
    applyStimulus(0, 0, 1, 1, 0, 8'($urandom), pickReady(rdyMode), 0, 1);
  endtask

  initial begin
    // Reset state
    applyStimulus(0, 0, 1, 1, 0, 8'h00, 0, 0, 0);
    applyStimulus(0, 0, 1, 1, 0, 8'h00, 0, 0, 0);
    check("reset Pix_data", {24'b0, Pix_data}, 32'd0);
    check("reset Pix_valid", {31'b0, Pix_valid}, 32'd0);
    check("reset Exp_cycles", {24'b0, Exp_cycles}, 32'd0);
    idleCycles(2, 1, 0);

    // Clean frame
    done_seen = 0;
    runFrame(10, 8, 5, 8'h3C, 8, 5, 8'h5A, 1, 0);
    idleCycles(3, 1, 0);
    check("clean Exp_cycles", {24'b0, Exp_cycles}, 32'd10);
    check("clean done count", done_seen, 32'd1);
    check("clean Proto_err", {31'b0, Proto_err}, 32'd0);

    // Backpressure then overrun
    done_seen = 0;
    runFrame(4, 5, 3, 8'hA1, 5, 3, 8'hB2, 0, 0);
    idleCycles(2, 0, 0);
    check("bp held valid", {31'b0, Pix_valid}, 32'd1);
    check("bp held head", {24'b0, Pix_data}, 32'hA1);
    check("bp first done", done_seen, 32'd1);
    done_seen = 0;
    runFrame(4, 5, 3, 8'hC3, 5, 3, 8'hD4, 0, 0);
    check("bp Overrun", {31'b0, Overrun}, 32'd1);
    check("bp second done", done_seen, 32'd0);
    idleCycles(4, 1, 0);
    idleCycles(1, 1, 1);
    check("bp Overrun cleared", {31'b0, Overrun}, 32'd0);

    // Both row enables low together
    applyStimulus(0, 0, 0, 0, 0, 8'h00, 1, 0, 1);
    check("both NRE Proto_err", {31'b0, Proto_err}, 32'd1);
    idleCycles(1, 1, 1);
    check("Err_clr Proto_err", {31'b0, Proto_err}, 32'd0);

    // Missing ADC in row 1
    done_seen = 0;
    runFrame(3, 8, 0, 8'h00, 4, 2, 8'h11, 1, 0);
    idleCycles(2, 1, 0);
    check("missing ADC Proto_err", {31'b0, Proto_err}, 32'd1);
    check("missing ADC done", done_seen, 32'd0);
    idleCycles(1, 1, 1);

    // Exposure saturation
    runFrame(300, 3, 2, 8'h01, 3, 2, 8'h02, 1, 0);
    check("sat Exp_cycles", {24'b0, Exp_cycles}, EXP_MAX);
    idleCycles(2, 1, 0);

    // Reset in the middle of row 2 with a sample buffered
    done_seen = 0;
    runFrame(3, 4, 2, 8'h77, 6, 3, 8'h88, 0, 4);
    check("midreset Pix_valid", {31'b0, Pix_valid}, 32'd0);
    check("midreset Proto_err", {31'b0, Proto_err}, 32'd0);
    check("midreset Exp_cycles", {24'b0, Exp_cycles}, 32'd0);
    idleCycles(3, 1, 0);
    check("midreset done", done_seen, 32'd0);

    // Random well-formed and slightly broken frames
    for (int f = 0; f < 25; f++) begin
      int r1, r2, a1, a2;
      r1 = $urandom_range(2, 6);
      r2 = $urandom_range(2, 6);
      a1 = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(2, r1);
      a2 = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(2, r2);
      runFrame($urandom_range(1, 8), r1, a1, 8'($urandom), r2, a2, 8'($urandom), 2, 0);
      idleCycles($urandom_range(0, 2), 2, logic'($urandom_range(0, 3) == 0));
    end

    // Random noise on every input
    for (int i = 0; i < 400; i++)
      applyStimulus($urandom_range(0, 15) == 0, $urandom_range(0, 3) == 0,
                    $urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0,
                    $urandom_range(0, 4) == 0, 8'($urandom), logic'($urandom_range(0, 1)),
                    $urandom_range(0, 7) == 0, $urandom_range(0, 49) != 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
